// File: rtl/board_generator_pkg.sv
// Shared Memory Matrix game definitions: board geometry, FSM encoding,
// LFSR constants and the tile-count clamp used when a start is accepted.
package board_generator_pkg;

  localparam int BOARD_W    = 16;
  localparam int IDX_W      = 4;
  localparam int TILE_CNT_W = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_SHOW  = 2'd2,
    ST_READY = 2'd3
  } bg_state_e;

  // A request for zero tiles still places one; requests above the board size
  // fill the whole board.
  function automatic logic [TILE_CNT_W-1:0] clamp_target(input logic [TILE_CNT_W-1:0] n);
    logic [TILE_CNT_W-1:0] t;
    if (n == 5'd0) begin
      t = 5'd1;
    end else if (n > TILE_CNT_W'(BOARD_W)) begin
      t = TILE_CNT_W'(BOARD_W);
    end else begin
      t = n;
    end
    return t;
  endfunction

endpackage

// File: rtl/board_generator_if.sv
// Request/board bundle between the game controller (master) and the
// board generator (slave).
interface board_generator_if;
  import board_generator_pkg::*;

  logic                  start;
  logic [TILE_CNT_W-1:0] num_tiles;
  logic [BOARD_W-1:0]    board;
  logic                  show;
  logic                  ready;
  logic                  busy;
  logic [TILE_CNT_W-1:0] tile_count;

  modport master (
    output start, num_tiles,
    input  board, show, ready, busy, tile_count
  );

  modport slave (
    input  start, num_tiles,
    output board, show, ready, busy, tile_count
  );

endinterface

// File: rtl/board_generator_lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR. Reset loads the seed;
// otherwise it steps every cycle. Only the low Q_W bits are exported so a
// consumer needing a few random bits does not carry the whole state.
module lfsr16
  import board_generator_pkg::*;
#(
  parameter int Q_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    seed,
  output logic [Q_W-1:0] q
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next LFSR value: shift right, fold the taps in when a one falls out.
  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) begin
      state_d = state_d ^ LFSR_TAPS;
    end else begin
      state_d = state_d;
    end
  end

  // LFSR state register; a non-zero seed keeps it off the all-zero lockup.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q[Q_W-1:0];

endmodule

// File: rtl/board_generator.sv
// Builds a random board with a requested number of tiles, reveals it for a
// fixed window, then holds it steady and flags it ready for guessing.
module board_generator
  import board_generator_pkg::*;
#(
  parameter logic [15:0] SEED        = LFSR_SEED,
  parameter int          SHOW_CYCLES = 50_000_000,
  parameter int          CNT_W       = 26
) (
  input  logic              clk,
  input  logic              reset,
  board_generator_if.slave  bus
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

  bg_state_e             state_q, state_d;
  logic [BOARD_W-1:0]    tiles_q, tiles_d;
  logic [TILE_CNT_W-1:0] tile_count_q, tile_count_d;
  logic [TILE_CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BOARD_W-1:0]    board_q, board_d;
  logic                  show_q, show_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [IDX_W-1:0]      gen_idx;

  lfsr16 #(
    .Q_W (IDX_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (gen_idx)
  );

  // Next-state, tile placement and reveal counter.
  always_comb begin
    state_d      = state_q;
    tiles_d      = tiles_q;
    tile_count_d = tile_count_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (bus.start) begin
          target_d     = clamp_target(bus.num_tiles);
          tiles_d      = {BOARD_W{1'b0}};
          tile_count_d = 5'd0;
          state_d      = ST_GEN;
        end else begin
          state_d = state_q;
        end
      end
      ST_GEN: begin
        // A collision leaves everything unchanged; the LFSR moves on anyway.
        if (!tiles_q[gen_idx]) begin
          tiles_d[gen_idx] = 1'b1;
          tile_count_d     = tile_count_q + 5'd1;
          if (tile_count_d == target_q) begin
            state_d = ST_SHOW;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_GEN;
          end
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_SHOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from next state so the
  // registered outputs line up exactly with the state they describe.
  always_comb begin
    show_d  = (state_d == ST_SHOW);
    ready_d = (state_d == ST_READY);
    busy_d  = (state_d == ST_GEN) || (state_d == ST_SHOW);
    if (show_d || ready_d) begin
      board_d = tiles_d;
    end else begin
      board_d = {BOARD_W{1'b0}};
    end
  end

  // State, tile mask, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tiles_q      <= {BOARD_W{1'b0}};
      tile_count_q <= 5'd0;
      target_q     <= 5'd0;
      cnt_q        <= {CNT_W{1'b0}};
      board_q      <= {BOARD_W{1'b0}};
      show_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tiles_q      <= tiles_d;
      tile_count_q <= tile_count_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      board_q      <= board_d;
      show_q       <= show_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.board      = board_q;
  assign bus.show       = show_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.tile_count = tile_count_q;

endmodule

// File: tb/tb_board_generator.sv
// Scoreboard bench for board_generator: a reference LFSR runs alongside the
// DUT, each accepted start pushes the predicted board and GEN length, and the
// prediction is popped when the board reaches READY.
module tb_board_generator;

  localparam int          SHOW_N    = 10;
  localparam int          GEN_LIMIT = 4000;
  localparam logic [15:0] TB_SEED   = 16'hACE1;

  typedef struct packed {
    logic [15:0] board;
    logic [4:0]  target;
    logic [31:0] gen_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  board_generator_if bus_if();

  board_generator #(
    .SEED        (TB_SEED),
    .SHOW_CYCLES (SHOW_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];
  logic [15:0] model_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int popcount16(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference LFSR: seed in reset, one step per clock otherwise.
  always @(posedge clk) begin
    if (reset) model_lfsr <= TB_SEED;
    else       model_lfsr <= lfsr_step(model_lfsr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start, predict the resulting board and check GEN entry.
  task automatic issue_start(input logic [4:0] n);
    exp_t        e;
    logic [15:0] l;
    logic [15:0] b;
    int          c;
    int          g;
    int          tgt;
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.num_tiles = n;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    tgt = (n == 5'd0) ? 1 : ((int'(n) > 16) ? 16 : int'(n));
    l = model_lfsr;
    b = 16'h0000;
    c = 0;
    g = 0;
    while (c < tgt && g < 70000) begin
      if (!b[l[3:0]]) begin
        b[l[3:0]] = 1'b1;
        c++;
      end
      g++;
      l = lfsr_step(l);
    end
    e.board      = b;
    e.target     = 5'(tgt);
    e.gen_cycles = 32'(g);
    exp_q.push_back(e);
    check_eq("busy_after_start", 32'(bus_if.busy), 32'd1);
    check_eq("ready_after_start", 32'(bus_if.ready), 32'd0);
    check_eq("tcount_after_start", 32'(bus_if.tile_count), 32'd0);
  endtask

  // Count GEN cycles until show rises; optionally poke start in GEN.
  task automatic wait_show(input bit disturb, output int g);
    g = 0;
    for (int i = 0; i < GEN_LIMIT; i++) begin
      @(negedge clk);
      if (bus_if.show) break;
      g++;
      bus_if.start     = disturb && (g == 1);
      bus_if.num_tiles = 5'd16;
    end
    bus_if.start = 1'b0;
    check_eq("show_rise", 32'(bus_if.show), 32'd1);
  endtask

  // Pop the prediction and check GEN length, reveal window and READY board.
  task automatic wait_and_check(input bit dis_gen, input bit dis_show, output logic [15:0] b_obs);
    exp_t e;
    int   g;
    int   s;
    e = exp_q.pop_front();
    wait_show(dis_gen, g);
    check_eq("gen_cycles", 32'(g), e.gen_cycles);
    s = 0;
    for (int i = 0; i < SHOW_N + 5; i++) begin
      if (!bus_if.show) break;
      s++;
      if (s == 1) check_eq("board_in_show", 32'(bus_if.board), 32'(e.board));
      bus_if.start     = dis_show && (s == 3);
      bus_if.num_tiles = 5'd16;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    check_eq("show_len", 32'(s), 32'(SHOW_N));
    check_eq("ready_level", 32'(bus_if.ready), 32'd1);
    check_eq("busy_in_ready", 32'(bus_if.busy), 32'd0);
    check_eq("board_ready", 32'(bus_if.board), 32'(e.board));
    check_eq("tile_count", 32'(bus_if.tile_count), 32'(e.target));
    check_eq("popcount_eq_target", 32'(popcount16(bus_if.board)), 32'(e.target));
    b_obs = bus_if.board;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] b;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] ref_board;
    int          changed;
    int          g;

    // 1: reset with start held high must leave everything idle
    reset            = 1'b1;
    bus_if.start     = 1'b1;
    bus_if.num_tiles = 5'd5;
    repeat (2) @(negedge clk);
    check_eq("rst_board", 32'(bus_if.board), 32'd0);
    check_eq("rst_show", 32'(bus_if.show), 32'd0);
    check_eq("rst_ready", 32'(bus_if.ready), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_tcount", 32'(bus_if.tile_count), 32'd0);
    reset        = 1'b0;
    bus_if.start = 1'b0;
    @(negedge clk);
    check_eq("rst_start_ignored", 32'(bus_if.busy), 32'd0);

    // 2: five tiles, reveal window, then a stable board
    issue_start(5'd5);
    wait_and_check(1'b0, 1'b0, b);
    ref_board = bus_if.board;
    changed   = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.board !== ref_board || bus_if.ready !== 1'b1) changed++;
    end
    check_eq("hold_100", 32'(changed), 32'd0);

    // 3: clamp boundaries
    issue_start(5'd0);
    wait_and_check(1'b0, 1'b0, b);
    check_eq("pop_n0", 32'(popcount16(b)), 32'd1);
    issue_start(5'd20);
    wait_and_check(1'b0, 1'b0, b);
    check_eq("board_full", 32'(b), 32'h0000FFFF);
    check_eq("tcount_full", 32'(bus_if.tile_count), 32'd16);

    // 4: starts during GEN and SHOW are ignored
    issue_start(5'd6);
    wait_and_check(1'b1, 1'b1, b);

    // 5: reset on the 3rd SHOW cycle, then a fresh board
    issue_start(5'd4);
    void'(exp_q.pop_front());
    wait_show(1'b0, g);
    repeat (2) @(negedge clk);
    check_eq("show_pre_reset", 32'(bus_if.show), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_board", 32'(bus_if.board), 32'd0);
    check_eq("mid_rst_show", 32'(bus_if.show), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_if.ready), 32'd0);
    check_eq("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("mid_rst_tcount", 32'(bus_if.tile_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    issue_start(5'd9);
    wait_and_check(1'b0, 1'b0, b);

    // 6: determinism from reset, then restart straight from READY
    do_reset();
    repeat (5) @(negedge clk);
    issue_start(5'd7);
    wait_and_check(1'b0, 1'b0, b1);
    do_reset();
    repeat (5) @(negedge clk);
    issue_start(5'd7);
    wait_and_check(1'b0, 1'b0, b2);
    check_eq("determinism", 32'(b2), 32'(b1));
    issue_start(5'd3);
    wait_and_check(1'b0, 1'b0, b);
    check_eq("pop_n3", 32'(popcount16(b)), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/board_generator.md
Name: board_generator

Overview:
Upstream stage of the guess checker in the Memory Matrix game. On a start request it builds a random board bitmask with exactly N tiles set, using a free-running LFSR. It then asserts a timed reveal window so the player can memorise the pattern, and finally holds the board steady and flags it ready for the guess-checking stage. The guess checker and remaining-guess counter consume board and ready.

Parameters:
BOARD_W, 16, number of tiles; must be a power of 2, max 16.
IDX_W, 4, log2(BOARD_W); tile index width.
SEED, 16'hACE1, LFSR reset value; must be non-zero.
SHOW_CYCLES, 50_000_000, reveal-window length in clk cycles (1 s at 50 MHz).
CNT_W, 26, reveal counter width; must satisfy 2^CNT_W > SHOW_CYCLES.

Ports:
clk  input  1  system clock (CLOCK_50 domain).
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request for a new board.
num_tiles  input  5  requested tile count; sampled only when start is accepted.
board  output  BOARD_W  tile mask; forced 0 unless show or ready is high.
show  output  1  high during the reveal window.
ready  output  1  board is valid for guessing; level signal.
busy  output  1  high in GEN or SHOW.
tile_count  output  5  tiles placed so far (debug).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Values after reset: state=IDLE, tiles=0, tile_count=0, reveal counter=0, lfsr=SEED. Outputs board=0, show=0, ready=0, busy=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, feedback mask 16'hB400, shifted right.
  - Advances every cycle in every state except during reset. Player timing therefore supplies entropy.
  - Never reaches zero.
- Target count: target = clamp(num_tiles), latched when start is accepted.
  - num_tiles=0 gives target=1.
  - num_tiles>BOARD_W gives target=BOARD_W.
- States: IDLE, GEN, SHOW, READY.
  - IDLE: on start, latch target, clear tiles and tile_count, go to GEN on the next cycle.
  - GEN: each cycle, idx = lfsr[IDX_W-1:0].
    - If tiles[idx]==0: set tiles[idx] and increment tile_count.
    - If tiles[idx]==1 (collision): no change; retry next cycle.
    - When tile_count reaches target (the updated count equals target), go to SHOW on the next cycle and clear the reveal counter.
    - Minimum GEN duration is target cycles. Termination is guaranteed: every idx value recurs within one LFSR period (65535 cycles).
  - SHOW: show=1, board=tiles. Counter increments each cycle. When the counter reaches SHOW_CYCLES-1, go to READY. show is high for exactly SHOW_CYCLES cycles.
  - READY: ready=1, board=tiles, held indefinitely. On start, behave as in IDLE: clear tiles, latch a new target, go to GEN. ready drops in the cycle after start.
- start is ignored in GEN and SHOW. No queuing.
- Reset takes priority over everything. Reset asserted in any state returns to IDLE and zeroes all outputs in the following cycle.
- board, show, ready and busy are driven from registered state and tiles. No combinational path from start to any output.
- Invariant: popcount(tiles)==tile_count at all times, and tile_count<=target.

Decomposition:
- Shared game package: BOARD_W, IDX_W, the state encoding (IDLE=0, GEN=1, SHOW=2, READY=3), LFSR_TAPS=16'hB400, and SEED. The guess checker uses the same BOARD_W.
- One sub-module: lfsr16 (clk, reset, seed load, q). It is reused later for other randomised game features.
- The FSM, tile placement and reveal counter stay in board_generator.

Test Plan:
Bench uses SHOW_CYCLES=10.
1. Assert reset for 2 cycles -> board=0, show=0, ready=0, busy=0, tile_count=0. start pulsed during reset has no effect.
2. start with num_tiles=5 -> busy rises next cycle; show rises with popcount(board)=5. show stays high exactly 10 cycles, then ready=1. board is unchanged for 100 further cycles.
3. num_tiles=0 -> popcount(board)=1. num_tiles=20 -> board=16'hFFFF, tile_count=16.
4. start pulsed mid-GEN and mid-SHOW -> ignored: target, board and timing are identical to an undisturbed run.
5. reset asserted on the 3rd SHOW cycle -> next cycle all outputs are 0 and state is IDLE. A new start then produces a fresh board.
6. Determinism: reset, then start at the same cycle offset twice with num_tiles=7 -> identical boards. start in READY with num_tiles=3 -> ready drops next cycle and the new board has popcount 3.
